// File: rtl/multi_alarm_clock_core_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : alarm_clock_pkg
//  Description : Shared types, time limits and wrap helpers for the alarm core.
//  Revision    : 1.0 - initial release
// ============================================================================
package alarm_clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN       = 2'd0,
        MODE_SET_TIME  = 2'd1,
        MODE_SET_ALARM = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        RING_IDLE    = 2'd0,
        RING_RINGING = 2'd1,
        RING_SNOOZE  = 2'd2
    } ring_state_e;

    localparam logic [7:0] MAX_HOURS = 8'd23;
    localparam logic [7:0] MAX_MINS  = 8'd59;

    function automatic logic [7:0] wrap_inc(input logic [7:0] v, input logic [7:0] max_v);
        return (v >= max_v) ? 8'd0 : v + 8'd1;
    endfunction

    function automatic mode_e next_mode(input mode_e m);
        case (m)
            MODE_RUN:      return MODE_SET_TIME;
            MODE_SET_TIME: return MODE_SET_ALARM;
            default:       return MODE_RUN;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/multi_alarm_clock_core_if.sv
`default_nettype none
// ============================================================================
//  Interface   : multi_alarm_clock_core_if
//  Description : Button pulses in, time/alarm/ring status out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface multi_alarm_clock_core_if #(
    parameter int NUM_ALARMS = 4,
    parameter int IDX_W      = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
);
    logic                  btn_mode;
    logic                  btn_inc_hours;
    logic                  btn_inc_mins;
    logic                  btn_next_alarm;
    logic                  btn_toggle_enable;
    logic                  btn_snooze;
    logic                  btn_stop;
    logic [7:0]            real_hours;
    logic [7:0]            real_mins;
    logic [7:0]            disp_hours;
    logic [7:0]            disp_mins;
    logic [1:0]            mode;
    logic [IDX_W-1:0]      sel_alarm;
    logic [NUM_ALARMS-1:0] alarm_enabled;
    logic                  ringing;
    logic                  snoozing;
    logic [IDX_W-1:0]      ring_idx;
    logic                  speaker_out;

    modport master (
        output btn_mode, btn_inc_hours, btn_inc_mins, btn_next_alarm,
               btn_toggle_enable, btn_snooze, btn_stop,
        input  real_hours, real_mins, disp_hours, disp_mins, mode, sel_alarm,
               alarm_enabled, ringing, snoozing, ring_idx, speaker_out
    );

    modport slave (
        input  btn_mode, btn_inc_hours, btn_inc_mins, btn_next_alarm,
               btn_toggle_enable, btn_snooze, btn_stop,
        output real_hours, real_mins, disp_hours, disp_mins, mode, sel_alarm,
               alarm_enabled, ringing, snoozing, ring_idx, speaker_out
    );
endinterface
`default_nettype wire

// File: rtl/multi_alarm_clock_core_hm_counter.sv
`default_nettype none
// ============================================================================
//  Module      : hm_counter
//  Description : Hours/minutes register pair; advance carries, inc_* do not.
//  Revision    : 1.0 - initial release
// ============================================================================
module hm_counter
    import alarm_clock_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       advance_i,
    input  logic       inc_hours_i,
    input  logic       inc_mins_i,
    output logic [7:0] hours_o,
    output logic [7:0] mins_o
);
    logic [7:0] hours_q, hours_d;
    logic [7:0] mins_q, mins_d;

    always_comb begin
        hours_d = hours_q;
        mins_d  = mins_q;
        if (advance_i) begin
            mins_d = wrap_inc(mins_q, MAX_MINS);
            if (mins_q == MAX_MINS) begin
                hours_d = wrap_inc(hours_q, MAX_HOURS);
            end
        end else begin
            if (inc_hours_i) hours_d = wrap_inc(hours_q, MAX_HOURS);
            if (inc_mins_i)  mins_d  = wrap_inc(mins_q, MAX_MINS);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hours_q <= 8'd0;
            mins_q  <= 8'd0;
        end else begin
            hours_q <= hours_d;
            mins_q  <= mins_d;
        end
    end

    assign hours_o = hours_q;
    assign mins_o  = mins_q;
endmodule
`default_nettype wire

// File: rtl/multi_alarm_clock_core.sv
`default_nettype none
// ============================================================================
//  Module      : multi_alarm_clock_core
//  Description : Timekeeping, NUM_ALARMS alarm slots, snooze/timeout ring FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_alarm_clock_core
    import alarm_clock_pkg::*;
#(
    parameter int          NUM_ALARMS        = 4,
    parameter int unsigned TICKS_PER_MIN     = 32'd3000000000,
    parameter int          SNOOZE_MINS       = 9,
    parameter int          RING_TIMEOUT_MINS = 10,
    parameter int          TONE_DIV          = 25000
) (
    input  logic                      clk,
    input  logic                      reset,
    multi_alarm_clock_core_if.slave   bus
);
    localparam int IDX_W  = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
    localparam int PRE_W  = $clog2(TICKS_PER_MIN);
    localparam int TONE_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(TICKS_PER_MIN - 1);
    localparam logic [TONE_W-1:0] TONE_MAX = TONE_W'(TONE_DIV - 1);

    mode_e            mode_q, mode_d;
    ring_state_e      state_q, state_d;
    logic [IDX_W-1:0] sel_q, sel_d, ring_idx_q, ring_idx_d;
    logic [NUM_ALARMS-1:0] en_q, en_d;
    logic [7:0]       alm_h_q [NUM_ALARMS];
    logic [7:0]       alm_h_d [NUM_ALARMS];
    logic [7:0]       alm_m_q [NUM_ALARMS];
    logic [7:0]       alm_m_d [NUM_ALARMS];
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [5:0]       snooze_q, snooze_d, ep_q, ep_d;
    logic [TONE_W-1:0] tone_q, tone_d;
    logic             spk_q, spk_d, adv_q;
    logic [7:0]       real_h, real_m;
    logic             min_tick, stop_press, snooze_press, other_press;
    logic             match_any;
    logic [IDX_W-1:0] match_idx;

    // Only the highest-priority button class present in a cycle takes effect.
    assign stop_press   = bus.btn_stop & ~bus.btn_mode;
    assign snooze_press = bus.btn_snooze & ~bus.btn_mode & ~bus.btn_stop;
    assign other_press  = ~(bus.btn_mode | bus.btn_stop | bus.btn_snooze);
    assign min_tick     = (mode_q != MODE_SET_TIME) && (pre_q == PRE_MAX);

    hm_counter u_time (
        .clk         (clk),
        .reset       (reset),
        .advance_i   (min_tick),
        .inc_hours_i (other_press && mode_q == MODE_SET_TIME && bus.btn_inc_hours),
        .inc_mins_i  (other_press && mode_q == MODE_SET_TIME && bus.btn_inc_mins),
        .hours_o     (real_h),
        .mins_o      (real_m)
    );

    // Downward scan so the lowest matching slot is the one that sticks.
    always_comb begin
        match_any = 1'b0;
        match_idx = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (en_q[i] && alm_h_q[i] == real_h && alm_m_q[i] == real_m) begin
                match_any = 1'b1;
                match_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        mode_d     = mode_q;
        sel_d      = sel_q;
        en_d       = en_q;
        alm_h_d    = alm_h_q;
        alm_m_d    = alm_m_q;
        state_d    = state_q;
        ring_idx_d = ring_idx_q;
        snooze_d   = snooze_q;
        ep_d       = ep_q;
        tone_d     = '0;
        spk_d      = 1'b0;

        if (bus.btn_mode) mode_d = next_mode(mode_q);

        if (other_press && mode_q == MODE_SET_ALARM) begin
            if (bus.btn_next_alarm)
                sel_d = (sel_q == IDX_W'(NUM_ALARMS - 1)) ? '0 : sel_q + 1'b1;
            if (bus.btn_toggle_enable) en_d[sel_q] = ~en_q[sel_q];
            if (bus.btn_inc_hours) alm_h_d[sel_q] = wrap_inc(alm_h_q[sel_q], MAX_HOURS);
            if (bus.btn_inc_mins)  alm_m_d[sel_q] = wrap_inc(alm_m_q[sel_q], MAX_MINS);
        end

        pre_d = (mode_q == MODE_SET_TIME || mode_d == MODE_SET_TIME || min_tick)
                ? '0 : pre_q + 1'b1;

        case (state_q)
            RING_IDLE: begin
                if (adv_q && mode_q == MODE_RUN && match_any) begin
                    state_d    = RING_RINGING;
                    ring_idx_d = match_idx;
                    ep_d       = '0;
                end
            end
            RING_RINGING: begin
                if (stop_press) begin
                    state_d = RING_IDLE;
                end else if (snooze_press) begin
                    state_d  = RING_SNOOZE;
                    snooze_d = 6'(SNOOZE_MINS);
                end else if (min_tick) begin
                    if (ep_q == 6'(RING_TIMEOUT_MINS - 1)) state_d = RING_IDLE;
                    else                                   ep_d    = ep_q + 6'd1;
                end
            end
            RING_SNOOZE: begin
                if (stop_press) begin
                    state_d = RING_IDLE;
                end else if (min_tick) begin
                    if (snooze_q == 6'd1) begin
                        state_d = RING_RINGING;
                        ep_d    = '0;
                    end else begin
                        snooze_d = snooze_q - 6'd1;
                    end
                end
            end
            default: state_d = RING_IDLE;
        endcase

        // Disabling the slot that is currently sounding silences it.
        if (other_press && mode_q == MODE_SET_ALARM && bus.btn_toggle_enable &&
            sel_q == ring_idx_q && state_q != RING_IDLE)
            state_d = RING_IDLE;
        if (bus.btn_mode) state_d = RING_IDLE;

        if (state_q == RING_RINGING && state_d == RING_RINGING) begin
            if (tone_q == TONE_MAX) begin
                tone_d = '0;
                spk_d  = ~spk_q;
            end else begin
                tone_d = tone_q + 1'b1;
                spk_d  = spk_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q     <= MODE_RUN;
            state_q    <= RING_IDLE;
            sel_q      <= '0;
            ring_idx_q <= '0;
            en_q       <= '0;
            pre_q      <= '0;
            snooze_q   <= '0;
            ep_q       <= '0;
            tone_q     <= '0;
            spk_q      <= 1'b0;
            adv_q      <= 1'b0;
            for (int i = 0; i < NUM_ALARMS; i++) begin
                alm_h_q[i] <= 8'd0;
                alm_m_q[i] <= 8'd0;
            end
        end else begin
            mode_q     <= mode_d;
            state_q    <= state_d;
            sel_q      <= sel_d;
            ring_idx_q <= ring_idx_d;
            en_q       <= en_d;
            pre_q      <= pre_d;
            snooze_q   <= snooze_d;
            ep_q       <= ep_d;
            tone_q     <= tone_d;
            spk_q      <= spk_d;
            adv_q      <= min_tick && (mode_q == MODE_RUN);
            alm_h_q    <= alm_h_d;
            alm_m_q    <= alm_m_d;
        end
    end

    assign bus.real_hours    = real_h;
    assign bus.real_mins     = real_m;
    assign bus.disp_hours    = (mode_q == MODE_SET_ALARM) ? alm_h_q[sel_q] : real_h;
    assign bus.disp_mins     = (mode_q == MODE_SET_ALARM) ? alm_m_q[sel_q] : real_m;
    assign bus.mode          = mode_q;
    assign bus.sel_alarm     = sel_q;
    assign bus.alarm_enabled = en_q;
    assign bus.ringing       = (state_q == RING_RINGING);
    assign bus.snoozing      = (state_q == RING_SNOOZE);
    assign bus.ring_idx      = ring_idx_q;
    assign bus.speaker_out   = spk_q;
endmodule
`default_nettype wire

// File: tb/tb_multi_alarm_clock_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multi_alarm_clock_core
//  Description : Directed bench: 4-cycle minutes, snooze 2, timeout 3, tone 2.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_alarm_clock_core;
    localparam int NA = 4;
    localparam int B_MODE = 0, B_INC_H = 1, B_INC_M = 2, B_NEXT = 3,
                   B_TOGGLE = 4, B_SNOOZE = 5, B_STOP = 6;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;

    multi_alarm_clock_core_if #(.NUM_ALARMS(NA)) bus ();

    multi_alarm_clock_core #(
        .NUM_ALARMS(NA), .TICKS_PER_MIN(4), .SNOOZE_MINS(2),
        .RING_TIMEOUT_MINS(3), .TONE_DIV(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic clear_btns();
        bus.btn_mode = 1'b0;          bus.btn_inc_hours = 1'b0;
        bus.btn_inc_mins = 1'b0;      bus.btn_next_alarm = 1'b0;
        bus.btn_toggle_enable = 1'b0; bus.btn_snooze = 1'b0;
        bus.btn_stop = 1'b0;
    endtask

    task automatic press(input int b);
        @(negedge clk);
        case (b)
            B_MODE:   bus.btn_mode = 1'b1;
            B_INC_H:  bus.btn_inc_hours = 1'b1;
            B_INC_M:  bus.btn_inc_mins = 1'b1;
            B_NEXT:   bus.btn_next_alarm = 1'b1;
            B_TOGGLE: bus.btn_toggle_enable = 1'b1;
            B_SNOOZE: bus.btn_snooze = 1'b1;
            default:  bus.btn_stop = 1'b1;
        endcase
        @(negedge clk);
        clear_btns();
    endtask

    task automatic press_n(input int b, input int n);
        for (int i = 0; i < n; i++) press(b);
    endtask

    task automatic wait_min(input string tag);
        logic [7:0] m0;
        int n;
        m0 = bus.real_mins;
        n  = 0;
        while (bus.real_mins == m0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(bus.real_mins != m0), 1);
    endtask

    task automatic wait_ring(input string tag, input int bound);
        int n = 0;
        while (!bus.ringing && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(tag, bus.ringing, 1);
    endtask

    task automatic check_reset_state(input string pfx);
        check({pfx, " hours"},    bus.real_hours, 0);
        check({pfx, " mins"},     bus.real_mins, 0);
        check({pfx, " disp_h"},   bus.disp_hours, 0);
        check({pfx, " disp_m"},   bus.disp_mins, 0);
        check({pfx, " mode"},     bus.mode, 0);
        check({pfx, " sel"},      bus.sel_alarm, 0);
        check({pfx, " enabled"},  bus.alarm_enabled, 0);
        check({pfx, " ringing"},  bus.ringing, 0);
        check({pfx, " snoozing"}, bus.snoozing, 0);
        check({pfx, " ring_idx"}, bus.ring_idx, 0);
        check({pfx, " speaker"},  bus.speaker_out, 0);
    endtask

    initial begin
        logic spk_exp [4];
        int   n;
        spk_exp = '{1'b0, 1'b1, 1'b1, 1'b0};
        clear_btns();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_reset_state("reset");

        // Free-running day: one minute per four cycles.
        repeat (4) @(negedge clk);
        check("t1 00:01 mins", bus.real_mins, 1);
        repeat (236) @(negedge clk);
        check("t1 01:00 hours", bus.real_hours, 1);
        check("t1 01:00 mins", bus.real_mins, 0);
        check("t1 disp_h", bus.disp_hours, 1);
        check("t1 disp_m", bus.disp_mins, 0);
        repeat (5516) @(negedge clk);
        check("t1 23:59 hours", bus.real_hours, 23);
        check("t1 23:59 mins", bus.real_mins, 59);
        repeat (4) @(negedge clk);
        check("t1 wrap hours", bus.real_hours, 0);
        check("t1 wrap mins", bus.real_mins, 0);

        // Manual time set, no carry, frozen prescaler.
        press(B_MODE);
        check("t2 mode", bus.mode, 1);
        press_n(B_INC_M, 61);
        press_n(B_INC_H, 25);
        check("t2 hours", bus.real_hours, 1);
        check("t2 mins", bus.real_mins, 1);
        repeat (20) @(negedge clk);
        check("t2 hold mins", bus.real_mins, 1);
        check("t2 disp_m", bus.disp_mins, 1);
        press(B_NEXT);
        check("t2 next ignored", bus.sel_alarm, 0);

        // Program slots 2 and 0 to 00:05.
        press(B_MODE);
        check("t3 mode", bus.mode, 2);
        press_n(B_NEXT, 2);
        check("t3 sel2", bus.sel_alarm, 2);
        press_n(B_INC_M, 5);
        press(B_TOGGLE);
        check("t3 en slot2", bus.alarm_enabled, 4'b0100);
        check("t3 disp_h", bus.disp_hours, 0);
        check("t3 disp_m", bus.disp_mins, 5);
        press_n(B_NEXT, 2);
        check("t3 sel wrap", bus.sel_alarm, 0);
        press_n(B_INC_M, 5);
        press(B_TOGGLE);
        check("t3 en both", bus.alarm_enabled, 4'b0101);
        press(B_MODE);
        check("t3 mode run", bus.mode, 0);
        press(B_TOGGLE);
        check("t3 toggle ignored", bus.alarm_enabled, 4'b0101);

        n = 0;
        while (!(bus.real_hours == 0 && bus.real_mins == 5) && n < 7000) begin
            @(negedge clk);
            n++;
        end
        check("t3 reach 00:05", 32'(bus.real_hours == 0 && bus.real_mins == 5), 1);
        check("t3 not yet ringing", bus.ringing, 0);
        @(negedge clk);
        check("t3 ringing", bus.ringing, 1);
        check("t3 ring_idx", bus.ring_idx, 0);
        check("t3 spk0", bus.speaker_out, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("t3 spk%0d", i + 1), bus.speaker_out, 32'(spk_exp[i]));
        end

        // Snooze re-arms after two minutes; stop beats snooze.
        press(B_SNOOZE);
        check("t4 snoozing", bus.snoozing, 1);
        check("t4 not ringing", bus.ringing, 0);
        check("t4 spk off", bus.speaker_out, 0);
        wait_min("t4 tick1");
        check("t4 still snoozing", bus.snoozing, 1);
        wait_min("t4 tick2");
        check("t4 re-ring", bus.ringing, 1);
        @(negedge clk);
        bus.btn_snooze = 1'b1;
        bus.btn_stop   = 1'b1;
        @(negedge clk);
        clear_btns();
        check("t4 stop ringing", bus.ringing, 0);
        check("t4 stop snoozing", bus.snoozing, 0);
        press(B_SNOOZE);
        check("t4 idle snooze ignored", bus.snoozing, 0);

        // Next day: ring times out after three minutes.
        wait_ring("t5 ring", 6500);
        check("t5 ring_idx", bus.ring_idx, 0);
        wait_min("t5 tick1");
        check("t5 ring after 1", bus.ringing, 1);
        wait_min("t5 tick2");
        check("t5 ring after 2", bus.ringing, 1);
        wait_min("t5 tick3");
        check("t5 timed out", bus.ringing, 0);
        check("t5 enabled kept", bus.alarm_enabled, 4'b0101);

        // Mode press kills the ring; then reset from SNOOZE.
        wait_ring("t6 ring", 6500);
        press(B_MODE);
        check("t6 idle", bus.ringing, 0);
        check("t6 mode", bus.mode, 1);
        check("t6 mins", bus.real_mins, 5);
        press_n(B_INC_M, 59);
        check("t6 set 00:04", bus.real_mins, 4);
        press(B_MODE);
        press(B_MODE);
        check("t6 mode run", bus.mode, 0);
        wait_ring("t6 re-ring", 20);
        check("t6 ring mins", bus.real_mins, 5);
        press(B_SNOOZE);
        check("t6 snoozing", bus.snoozing, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("t6 reset");
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/multi_alarm_clock_core.md
Name: multi_alarm_clock_core

Overview:
Parametrised timekeeping and alarm core for the alarm clock. It keeps hours and minutes from a prescaled system clock and holds NUM_ALARMS independently enabled alarms. It provides snooze, ring timeout and a square-wave speaker drive, plus a three-mode button interface.
It sits between the debounced-button front end and the 7-segment display decoder. It replaces the separate set-time and set-alarm interfaces.

Parameters:
NUM_ALARMS, 4, number of alarm slots (>=1); IDX_W = max(1, $clog2(NUM_ALARMS))
TICKS_PER_MIN, 3000000000, clk cycles per minute (>=2)
SNOOZE_MINS, 9, snooze length in minutes (1..63)
RING_TIMEOUT_MINS, 10, auto-stop after this many ringing minutes (1..63)
TONE_DIV, 25000, clk cycles per speaker half-period (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
btn_mode  in  1  cycles the mode RUN->SET_TIME->SET_ALARM->RUN
btn_inc_hours  in  1  increments hours of the selected target
btn_inc_mins  in  1  increments minutes of the selected target
btn_next_alarm  in  1  in SET_ALARM: sel_alarm+1, wrapping at NUM_ALARMS-1 -> 0
btn_toggle_enable  in  1  in SET_ALARM: inverts alarm_enabled[sel_alarm]
btn_snooze  in  1  snooze the ringing alarm
btn_stop  in  1  stop ringing or snoozing
real_hours  out  8  current time hours, 0..23, binary
real_mins  out  8  current time minutes, 0..59, binary
disp_hours  out  8  real time in RUN/SET_TIME; selected alarm hours in SET_ALARM
disp_mins  out  8  same selection rule as disp_hours, for minutes
mode  out  2  0=RUN, 1=SET_TIME, 2=SET_ALARM
sel_alarm  out  IDX_W  alarm slot being edited
alarm_enabled  out  NUM_ALARMS  per-slot enable flags
ringing  out  1  ring FSM is in RINGING
snoozing  out  1  ring FSM is in SNOOZE
ring_idx  out  IDX_W  slot that fired
speaker_out  out  1  square wave while ringing, else 0

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: time 00:00; every alarm 00:00 and disabled; mode=RUN; sel_alarm=0; ring FSM IDLE; ring_idx=0; speaker_out=0; all counters 0.
- Buttons: every btn_* input is a single-cycle, already-debounced pulse.
- Button priority within one cycle: btn_mode > btn_stop > btn_snooze > all other buttons.
- Prescaler counts 0..TICKS_PER_MIN-1 and pulses min_tick at the wrap. It runs only in RUN and SET_ALARM.
- Prescaler in SET_TIME: held at 0; leaving SET_TIME restarts it from 0.
- RUN time advance: min_tick advances the time. 59 minutes -> 0 with hours+1; 23:59 -> 00:00.
- SET_TIME edits the time. btn_inc_mins wraps 59->0 with no hour carry; btn_inc_hours wraps 23->0.
- SET_ALARM edits the selected alarm with the same wrap rules. The time keeps running in this mode.
- Edits and pulses register on the clk edge after the button pulse (1-cycle latency).
- Alarm match: after a min_tick-driven time update in RUN, ringing=1 one cycle later if an enabled slot equals the new time.
  - Lowest matching index wins and is latched into ring_idx.
  - Matches are evaluated only in RUN, only from IDLE, and only on minute advance. Manually setting the time onto an alarm time never fires.
- Ring FSM transitions:
  - IDLE -> RINGING on a match.
  - RINGING -> SNOOZE on btn_snooze; snooze counter loads SNOOZE_MINS.
  - SNOOZE: each min_tick decrements the counter; the tick that reaches 0 -> RINGING.
  - RINGING -> IDLE on btn_stop, or after RING_TIMEOUT_MINS min_ticks in the current RINGING episode. The episode counter clears on entry to RINGING.
  - SNOOZE -> IDLE on btn_stop.
  - Any btn_mode press forces IDLE.
  - Stopping leaves alarm_enabled unchanged, so the alarm fires again the next day.
- Toggling enable on a slot: if the slot equals ring_idx while RINGING or SNOOZE, the FSM goes to IDLE.
- Matches of other slots are ignored while RINGING or SNOOZE.
- Speaker: in RINGING, speaker_out toggles every TONE_DIV cycles. The tone counter and speaker_out clear to 0 on leaving RINGING.
- Snooze/stop in IDLE are ignored. next_alarm/toggle_enable outside SET_ALARM are ignored. inc_* in RUN is ignored.
- Mid-operation reset returns all state to reset values on the next clk edge.

Decomposition:
- Package alarm_clock_pkg:
  - mode_e {MODE_RUN, MODE_SET_TIME, MODE_SET_ALARM}
  - ring_state_e {RING_IDLE, RING_RINGING, RING_SNOOZE}
  - constants MAX_HOURS=23, MAX_MINS=59
- Sub-module hm_counter: an 8-bit hours/minutes register pair.
  - Inputs: advance (with carry), inc_hours and inc_mins (no carry).
  - Wrap rules as above.
  - Instantiated once for the time. The alarm slots use a plain register array with the same wrap helpers.

Test Plan (TICKS_PER_MIN=4, SNOOZE_MINS=2, RING_TIMEOUT_MINS=3, TONE_DIV=2, NUM_ALARMS=4):
1. Reset, then 24*60*4 cycles in RUN -> time passes 23:59 and returns to 00:00; disp_* tracks real_*.
2. SET_TIME: 61 inc_mins pulses, then 25 inc_hours pulses -> 01:01 with no minute carry; prescaler holds while in SET_TIME.
3. Program slot 2 = 00:05 and enable; program slot 0 = 00:05 and enable; RUN from 00:04 -> ringing one cycle after real_mins=5, ring_idx=0, speaker_out toggles every 2 cycles.
4. Ringing, then btn_snooze -> snoozing=1, speaker_out=0; two min_ticks later ringing=1. Pulse btn_snooze and btn_stop in the same cycle -> IDLE.
5. Ring left untouched -> IDLE after 3 min_ticks; alarm_enabled still set.
6. Ringing and btn_mode -> IDLE, mode=SET_TIME. Then reset asserted mid-SNOOZE -> all outputs at reset values next cycle.
